// File: rtl/irq_ctrl.sv
// Interrupt producer: synchronizes device lines, detects edge/level requests and
// holds them pending until a non-stalled delivery cycle. Optional IRQ_LOST_EN adds lost-request flags.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_MASK   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               stall,
    output logic [15:0]        interrupts,
    output logic [NUM_IRQ-1:0] irq_ack,
`ifdef IRQ_LOST_EN
    output logic [NUM_IRQ-1:0] irq_lost,
    input  logic [NUM_IRQ-1:0] irq_lost_clr,
`endif
    output logic               irq_busy
);

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] p;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] edge_sel;

    assign edge_sel = EDGE_MASK[NUM_IRQ-1:0];
    assign s        = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            p      <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            p <= s;
        end
    end

    // Level lines only request while not already pending, so a held line re-pends after each delivery.
    always_comb begin
        req = irq_enable & ((edge_sel & s & ~p) | (~edge_sel & s & ~pend));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            irq_ack <= '0;
        end else if (!stall) begin
            pend    <= req;
            irq_ack <= pend;
        end else begin
            pend    <= pend | req;
            irq_ack <= '0;
        end
    end

    always_comb begin
        interrupts                = '0;
        interrupts[NUM_IRQ-1:0]   = pend;
    end

    assign irq_busy = |pend;

`ifdef IRQ_LOST_EN
    logic [NUM_IRQ-1:0] lost_set;

    // A new edge merging into a bit that is held pending (not delivered this cycle) is lost.
    assign lost_set = edge_sel & req & pend & {NUM_IRQ{stall}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_lost <= '0;
        else
            irq_lost <= (irq_lost & ~irq_lost_clr) | lost_set;
    end
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl (line 5 configured level-triggered).
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irq_in;
    logic [15:0] irq_enable;
    logic        stall;
    logic [15:0] interrupts;
    logic [15:0] irq_ack;
    logic        irq_busy;
`ifdef IRQ_LOST_EN
    logic [15:0] irq_lost;
    logic [15:0] irq_lost_clr;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ     (16),
        .SYNC_STAGES (2),
        .EDGE_MASK   (16'hFFDF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .irq_enable   (irq_enable),
        .stall        (stall),
        .interrupts   (interrupts),
        .irq_ack      (irq_ack),
`ifdef IRQ_LOST_EN
        .irq_lost     (irq_lost),
        .irq_lost_clr (irq_lost_clr),
`endif
        .irq_busy     (irq_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_in     = '0;
        irq_enable = '1;
        stall      = 1'b0;
`ifdef IRQ_LOST_EN
        irq_lost_clr = '0;
`endif
        #12;
        check("rst_ints", 32'(interrupts), 32'h0);
        check("rst_ack",  32'(irq_ack),    32'h0);
        check("rst_busy", 32'(irq_busy),   32'h0);
        tick; tick;
        rst_n = 1'b1;
        tick; tick;

        // Edge line 3, 5-cycle pulse: pending on cycle 3, acked on cycle 4.
        irq_in[3] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            check("e3_ints", 32'(interrupts), (k == 3) ? 32'h0008 : 32'h0);
            check("e3_ack",  32'(irq_ack),    (k == 4) ? 32'h0008 : 32'h0);
            if (k == 5) irq_in[3] = 1'b0;
        end

        // Stalled collection of lines 0 and 7, then a single delivery.
        stall = 1'b1;
        irq_in[0] = 1'b1;
        irq_in[7] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k == 2) begin
                irq_in[0] = 1'b0;
                irq_in[7] = 1'b0;
            end
            if (k >= 3) begin
                check("st_ints", 32'(interrupts), 32'h0081);
                check("st_busy", 32'(irq_busy),   32'h1);
            end
            check("st_ack", 32'(irq_ack), 32'h0);
        end
        stall = 1'b0;
        tick;
        check("st_rel_ints", 32'(interrupts), 32'h0);
        check("st_rel_ack",  32'(irq_ack),    32'h0081);
        tick;
        check("st_rel_ack2", 32'(irq_ack),    32'h0);
        tick; tick;

        // Level line 5: alternates while held; one trailing assertion from the synchronizer after drop.
        irq_in[5] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick;
            check("lv_ints", 32'(interrupts),
                  (k == 3 || k == 5 || k == 7 || k == 9) ? 32'h0020 : 32'h0);
            check("lv_ack", 32'(irq_ack),
                  (k == 4 || k == 6 || k == 8 || k == 10) ? 32'h0020 : 32'h0);
            if (k == 7) irq_in[5] = 1'b0;
        end

        // Disabled line 2 discards; enabled line 2 delivers.
        irq_enable[2] = 1'b0;
        irq_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 3) irq_in[2] = 1'b0;
            check("dis_ints", 32'(interrupts), 32'h0);
            check("dis_ack",  32'(irq_ack),    32'h0);
        end
        irq_enable[2] = 1'b1;
        irq_in[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 3) irq_in[2] = 1'b0;
            check("en_ints", 32'(interrupts), (k == 3) ? 32'h0004 : 32'h0);
            check("en_ack",  32'(irq_ack),    (k == 4) ? 32'h0004 : 32'h0);
        end
        tick; tick;

        // Two edges on line 1 under stall merge into one request.
        stall = 1'b1;
        irq_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k == 2 || k == 6) irq_in[1] = 1'b0;
            if (k == 4) irq_in[1] = 1'b1;
            if (k >= 3) check("mg_ints", 32'(interrupts), 32'h0002);
            check("mg_ack", 32'(irq_ack), 32'h0);
`ifdef IRQ_LOST_EN
            check("mg_lost", 32'(irq_lost), (k >= 7) ? 32'h0002 : 32'h0);
`endif
        end
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            check("mg_rel_ints", 32'(interrupts), 32'h0);
            check("mg_rel_ack",  32'(irq_ack),    (k == 1) ? 32'h0002 : 32'h0);
        end
`ifdef IRQ_LOST_EN
        check("lost_hold", 32'(irq_lost), 32'h0002);
        irq_lost_clr[1] = 1'b1;
        tick;
        irq_lost_clr[1] = 1'b0;
        check("lost_clr", 32'(irq_lost), 32'h0);
        tick;
        check("lost_stay", 32'(irq_lost), 32'h0);
`endif

        // Reset during stall with requests pending.
        stall = 1'b1;
        irq_in[4] = 1'b1;
        irq_in[9] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 2) begin
                irq_in[4] = 1'b0;
                irq_in[9] = 1'b0;
            end
        end
        check("pre_rst_ints", 32'(interrupts), 32'h0210);
        rst_n = 1'b0;
        #1;
        check("async_ints", 32'(interrupts), 32'h0);
        check("async_ack",  32'(irq_ack),    32'h0);
        check("async_busy", 32'(irq_busy),   32'h0);
        tick;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            if (k == 2) stall = 1'b0;
            check("post_rst_ints", 32'(interrupts), 32'h0);
            check("post_rst_ack",  32'(irq_ack),    32'h0);
            check("post_rst_busy", 32'(irq_busy),   32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Producer side of the core's interrupt-pending interface. Collects asynchronous device interrupt lines, synchronizes them, and detects edges or levels per line.
- Holds each request pending until the control register file samples it. That file ORs `interrupts` into its pending register only on cycles where `stall` is low.
- Sits between the peripherals and the control register file. Returns a one-cycle acknowledge to each device on delivery.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; must be ≤ 16 to fit the `interrupts` field.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer; must be ≥ 2.
- EDGE_MASK, 16'hFFFF, per line: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  NUM_IRQ  raw device request lines, asynchronous to clk.
- irq_enable  in  NUM_IRQ  per-line enable; 0 = requests on that line are discarded.
- stall  in  1  pipeline stall; the same signal the control register file uses.
- interrupts  out  16  pending vector to the control register file; bits ≥ NUM_IRQ tie to 0.
- irq_ack  out  NUM_IRQ  one-cycle pulse per line when that line's request is delivered.
- irq_busy  out  1  OR of all pending bits.

Behaviour:
- Reset (rst_n low, asynchronous): synchronizer chain, previous-sample register, pending register, irq_ack and interrupts all go to 0.
- Synchronizer: irq_in passes through SYNC_STAGES flops; call the output s. A second register p holds s from the previous cycle.
- Request detection, per enabled line i:
  - Edge line: req[i] = s[i] & ~p[i].
  - Level line: req[i] = s[i] & ~pend[i].
  - Disabled line: req[i] = 0. A pending bit that is already set stays set when the line is later disabled.
- Delivery: interrupts = pend, taken directly from the register with no combinational path from stall.
  - A cycle with stall = 0 is a delivery cycle. The sink samples interrupts at that edge.
  - On a delivery cycle: next pend = req, and irq_ack = old pend, registered so it is high in the following cycle.
  - On a stall cycle: next pend = pend | req, and irq_ack = 0.
- Simultaneous set and deliver on the same bit: the set wins. The old request is delivered and acked, and the new one stays pending for the next delivery cycle.
- Latency: an edge on irq_in appears on interrupts SYNC_STAGES+1 cycles later. It is delivered at the first clk edge with stall = 0 after that. irq_ack pulses in the cycle after delivery.
- A level line held high re-pends in the cycle after delivery. The sink's OR is idempotent, so this is harmless.
- A repeated edge while a bit is still pending merges into the same request; no count is kept.
- Reset asserted mid-stall: pending requests are dropped and no ack is issued.
- irq_busy = |pend, combinational from the register.

Optional Feature:
- Macro: IRQ_LOST_EN.
- When defined: adds output irq_lost [NUM_IRQ]. This is a sticky flag, set when an edge-line req[i] arrives while pend[i] = 1 and that bit is not being delivered in that cycle. Also adds input irq_lost_clr [NUM_IRQ]; for each bit, a write of 1 clears the flag, and a set in the same cycle wins over the clear. Reset value is 0.
- When undefined: neither port exists and merging of requests is silent.

Test Plan:
- Reset, with irq_in = 0 and stall = 0: pulse irq_in[3] high for 5 cycles (SYNC_STAGES = 2). Expect interrupts = 16'h0008 on exactly 1 cycle, 3 cycles after the rise, and irq_ack[3] high the next cycle only.
- Hold stall = 1 for 10 cycles and pulse irq_in[0] and irq_in[7] during it. Expect interrupts = 16'h0081 held stable through the stall. Release stall: expect one delivery, then interrupts = 0 and irq_ack = 16'h0081 for 1 cycle.
- Level line (EDGE_MASK[5] = 0): hold irq_in[5] high with stall = 0. Expect interrupts[5] to alternate 1,0,1,0 starting 3 cycles after assertion. Drop irq_in[5]: within 3 cycles no further assertion of interrupts[5].
- irq_enable[2] = 0 and pulse irq_in[2]: interrupts stays 0. Set enable and pulse again: delivered normally.
- Under stall, pulse irq_in[1] twice, 4 cycles apart. Expect a single delivery and a single irq_ack[1]. With IRQ_LOST_EN defined, irq_lost[1] = 1 until irq_lost_clr[1] is pulsed.
- With requests pending and stall = 1, assert rst_n = 0 for 1 cycle. Expect interrupts, irq_ack and irq_busy to read 0 immediately (asynchronous) and stay 0 after release.
